// File: rtl/aes_block_arbiter.sv
// aes_block_arbiter: shares one AES datapath between two requesters,
// admitting whole blocks and steering each result block to its owner.
// Ports: clk_main_a0/rst_main_sync (sync, active-high); req0/req1
// valid/ready/data input words; aes_in_full/wr/din to the AES input FIFO;
// aes_out_empty/rd/dout from the AES output FIFO; rsp0/rsp1 valid/ready/data
// result words; busy, blocks_done, orphan_err status.
// Option: define AES_ARB_STRICT_PRIO_EN to make requester 0 win contention.
module aes_block_arbiter #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int TAG_DEPTH       = 8
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_sync,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        aes_in_full,
    output logic        aes_in_wr,
    output logic [31:0] aes_in_din,
    input  logic        aes_out_empty,
    output logic        aes_out_rd,
    input  logic [31:0] aes_out_dout,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic        busy,
    output logic [15:0] blocks_done,
    output logic        orphan_err
);

    localparam int CW = $clog2(WORDS_PER_BLOCK + 1);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [PW:0]   TAG_FULL  = (PW + 1)'(TAG_DEPTH);
    localparam logic [PW:0]   TAG_ONE   = (PW + 1)'(1);

    typedef enum logic [1:0] {I_IDLE, I_GRANT0, I_GRANT1} ing_state_t;
    typedef enum logic [1:0] {E_IDLE, E_RD, E_HOLD} egr_state_t;

    ing_state_t i_state, i_next;
    egr_state_t e_state, e_next;

    logic [CW-1:0]        i_cnt, e_cnt;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PW-1:0]        tag_wp, tag_rp;
    logic [PW:0]          tag_cnt;
    logic                 tag_full, tag_empty, tag_head;
    logic                 tag_push, tag_pop, push_id;
    logic                 win, in_xfer;
    logic                 rd_phase, capture, accept;

    assign tag_full  = (tag_cnt == TAG_FULL);
    assign tag_empty = (tag_cnt == '0);
    assign tag_head  = tag_mem[tag_rp];
    assign busy      = (i_state != I_IDLE) || !tag_empty;

`ifdef AES_ARB_STRICT_PRIO_EN
    assign win = !req0_valid;
`else
    // Requester preferred on the next simultaneous request.
    logic rr_pri;

    assign win = (req0_valid && req1_valid) ? rr_pri : req1_valid;

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rr_pri <= 1'b0;
        end else if (tag_push) begin
            rr_pri <= !push_id;
        end
    end
`endif

    // Ingress: grant a whole block, then pass words straight through.
    always_comb begin
        i_next     = i_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        aes_in_wr  = 1'b0;
        aes_in_din = '0;
        tag_push   = 1'b0;
        push_id    = 1'b0;
        in_xfer    = 1'b0;
        unique case (i_state)
            I_IDLE: begin
                if (!tag_full && (req0_valid || req1_valid)) begin
                    tag_push = 1'b1;
                    push_id  = win;
                    i_next   = win ? I_GRANT1 : I_GRANT0;
                end
            end
            I_GRANT0: begin
                req0_ready = !aes_in_full;
                aes_in_wr  = req0_valid && !aes_in_full;
                aes_in_din = req0_data;
                in_xfer    = aes_in_wr;
                if (in_xfer && (i_cnt == LAST_WORD)) begin
                    i_next = I_IDLE;
                end
            end
            I_GRANT1: begin
                req1_ready = !aes_in_full;
                aes_in_wr  = req1_valid && !aes_in_full;
                aes_in_din = req1_data;
                in_xfer    = aes_in_wr;
                if (in_xfer && (i_cnt == LAST_WORD)) begin
                    i_next = I_IDLE;
                end
            end
            default: i_next = I_IDLE;
        endcase
    end

    // Egress: E_RD spans the strobe cycle and the data-capture cycle.
    // An accepted word may chain straight into the next read.
    always_comb begin
        e_next     = e_state;
        aes_out_rd = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        tag_pop    = 1'b0;
        unique case (e_state)
            E_IDLE: begin
                if (!tag_empty && !aes_out_empty) begin
                    e_next = E_RD;
                end
            end
            E_RD: begin
                aes_out_rd = !rd_phase;
                if (rd_phase) begin
                    capture = 1'b1;
                    e_next  = E_HOLD;
                end
            end
            E_HOLD: begin
                accept = tag_head ? rsp1_ready : rsp0_ready;
                if (accept) begin
                    tag_pop = (e_cnt == LAST_WORD);
                    if (!aes_out_empty && (!tag_pop || (tag_cnt > TAG_ONE))) begin
                        e_next = E_RD;
                    end else begin
                        e_next = E_IDLE;
                    end
                end
            end
            default: e_next = E_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            i_state     <= I_IDLE;
            e_state     <= E_IDLE;
            i_cnt       <= '0;
            e_cnt       <= '0;
            rd_phase    <= 1'b0;
            tag_mem     <= '0;
            tag_wp      <= '0;
            tag_rp      <= '0;
            tag_cnt     <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_data   <= '0;
            rsp1_data   <= '0;
            blocks_done <= '0;
            orphan_err  <= 1'b0;
        end else begin
            i_state  <= i_next;
            e_state  <= e_next;
            rd_phase <= (e_state == E_RD) && !rd_phase;

            if (in_xfer) begin
                i_cnt <= (i_cnt == LAST_WORD) ? '0 : i_cnt + 1'b1;
            end
            if (accept) begin
                e_cnt <= (e_cnt == LAST_WORD) ? '0 : e_cnt + 1'b1;
            end

            if (tag_push) begin
                tag_mem[tag_wp] <= push_id;
                tag_wp          <= tag_wp + 1'b1;
            end
            if (tag_pop) begin
                tag_rp      <= tag_rp + 1'b1;
                blocks_done <= blocks_done + 1'b1;
            end
            unique case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase

            if (capture) begin
                if (tag_head) begin
                    rsp1_data  <= aes_out_dout;
                    rsp1_valid <= 1'b1;
                end else begin
                    rsp0_data  <= aes_out_dout;
                    rsp0_valid <= 1'b1;
                end
            end
            if (accept) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end

            // Result data with no owner on record is never read.
            if (tag_empty && !aes_out_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_arbiter.sv
// tb_aes_block_arbiter: directed/randomized bench for aes_block_arbiter
// with a loopback FIFO model and per-requester result scoreboards.
module tb_aes_block_arbiter;

    localparam int WPB = 4;
    localparam int TD  = 8;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_sync;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic        aes_in_full, aes_in_wr, aes_out_empty, aes_out_rd;
    logic [31:0] aes_in_din, aes_out_dout;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        busy, orphan_err;
    logic [15:0] blocks_done;

    always #5 clk_main_a0 = ~clk_main_a0;

    aes_block_arbiter #(.WORDS_PER_BLOCK(WPB), .TAG_DEPTH(TD)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_sync(rst_main_sync),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .aes_in_full(aes_in_full), .aes_in_wr(aes_in_wr), .aes_in_din(aes_in_din),
        .aes_out_empty(aes_out_empty), .aes_out_rd(aes_out_rd),
        .aes_out_dout(aes_out_dout),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .busy(busy), .blocks_done(blocks_done), .orphan_err(orphan_err)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] src0[$], src1[$], exp0[$], exp1[$], fq[$], inw[$];
    int  grants[$], exp_g[$];
    int  wr_cnt = 0, blk_wc = 0, stall = 0, stall_wr = 0, rd_cnt = 0;
    int  oe_mode = 0;
    bit  rand_rdy = 0, rand_full = 0, bp_arm = 0, saw_rsp1 = 0;
    bit  rd_h1 = 0, rd_h2 = 0, v0_prev = 0, v1_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = (src0.size() > 0);
        req0_data  = '0;
        if (src0.size() > 0) req0_data = src0[0];
        req1_valid = (src1.size() > 0);
        req1_data  = '0;
        if (src1.size() > 0) req1_data = src1[0];
        aes_in_full = (stall > 0) || (rand_full && ($urandom_range(4) == 0));
        if (stall > 0) stall--;
        aes_out_empty = (oe_mode == 1) ? 1'b1 :
                        (oe_mode == 2) ? 1'b0 : (fq.size() == 0);
        rsp0_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        rsp1_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    endtask

    // One clock: sample at the falling edge, update models after the rise.
    task automatic step();
        bit f0, f1, wr, rd;
        logic [31:0] din;
        @(negedge clk_main_a0);
        f0  = req0_valid && req0_ready;
        f1  = req1_valid && req1_ready;
        wr  = aes_in_wr;
        din = aes_in_din;
        rd  = aes_out_rd;
        if (wr) begin
            wr_cnt++;
            inw.push_back(din);
            if (aes_in_full) stall_wr++;
            if (blk_wc == 0) grants.push_back(int'(din[31]));
            blk_wc = (blk_wc + 1) % WPB;
        end
        if (rd) rd_cnt++;
        if (rsp1_valid) saw_rsp1 = 1;
        if (rd_h2) chk("rd_to_valid", 32'(rsp0_valid | rsp1_valid), 1);
        rd_h2 = rd_h1;
        rd_h1 = rd;
        if (v0_prev) chk("rsp0_hold", 32'(rsp0_valid), 1);
        if (v1_prev) chk("rsp1_hold", 32'(rsp1_valid), 1);
        v0_prev = rsp0_valid && !rsp0_ready;
        v1_prev = rsp1_valid && !rsp1_ready;
        if (rsp0_valid && rsp0_ready) begin
            chk("rsp0_pending", 32'(exp0.size() > 0), 1);
            if (exp0.size() > 0) chk("rsp0_data", rsp0_data, exp0.pop_front());
        end
        if (rsp1_valid && rsp1_ready) begin
            chk("rsp1_pending", 32'(exp1.size() > 0), 1);
            if (exp1.size() > 0) chk("rsp1_data", rsp1_data, exp1.pop_front());
        end
        @(posedge clk_main_a0);
        #1;
        if (rst_main_sync) begin
            fq.delete();
            aes_out_dout = '0;
            blk_wc  = 0;
            rd_h1   = 0;
            rd_h2   = 0;
            v0_prev = 0;
            v1_prev = 0;
        end else begin
            if (wr) fq.push_back(din);
            if (rd && (fq.size() > 0)) aes_out_dout = fq.pop_front();
            if (f0 && (src0.size() > 0)) src0.delete(0);
            if (f1 && (src1.size() > 0)) src1.delete(0);
            if (wr && bp_arm && (blk_wc == 2)) begin
                stall  = 5;
                bp_arm = 0;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        src0.delete();
        src1.delete();
        stall = 0;
        rst_main_sync = 1'b1;
        drive();
        step();
        step();
        rst_main_sync = 1'b0;
        exp0.delete();
        exp1.delete();
        drive();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy0"}, 32'(req0_ready), 0);
        chk({tag, "_rdy1"}, 32'(req1_ready), 0);
        chk({tag, "_wr"}, 32'(aes_in_wr), 0);
        chk({tag, "_rd"}, 32'(aes_out_rd), 0);
        chk({tag, "_v0"}, 32'(rsp0_valid), 0);
        chk({tag, "_v1"}, 32'(rsp1_valid), 0);
        chk({tag, "_d0"}, rsp0_data, 0);
        chk({tag, "_d1"}, rsp1_data, 0);
        chk({tag, "_done"}, 32'(blocks_done), 0);
        chk({tag, "_orph"}, 32'(orphan_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic add_block(input int id);
        logic [31:0] w;
        for (int i = 0; i < WPB; i++) begin
            w = $urandom();
            w[31] = id[0];
            if (id == 0) begin
                src0.push_back(w);
                exp0.push_back(w);
            end else begin
                src1.push_back(w);
                exp1.push_back(w);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (((exp0.size() + exp1.size()) != 0) && (n < budget)) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp0.size() + exp1.size()), 0);
    endtask

    initial begin
        int w0, d0, n, n0, n1, last, g;
        logic [31:0] blk[$];
        rst_main_sync = 1'b1;
        aes_out_dout  = '0;
        drive();

        // Reset state
        do_reset();
        check_reset_vals("reset");

        // Single block from requester 0
        saw_rsp1 = 0;
        inw.delete();
        for (int i = 0; i < WPB; i++) begin
            src0.push_back(32'h11111111 * 32'(i + 1));
            exp0.push_back(32'h11111111 * 32'(i + 1));
        end
        drive();
        drain(200);
        chk("single_done", 32'(blocks_done), 1);
        chk("single_rsp1_quiet", 32'(saw_rsp1), 0);
        chk("single_writes", 32'(inw.size()), WPB);
        for (int i = 0; i < inw.size(); i++)
            chk("single_word", inw[i], 32'h11111111 * 32'(i + 1));
        chk("single_idle_busy", 32'(busy), 0);

        // Simultaneous requests straight after reset
        do_reset();
        grants.delete();
        rand_rdy  = 1;
        rand_full = 1;
        add_block(0);
        add_block(0);
        add_block(1);
        add_block(1);
        drive();
        drain(1000);
        rand_full = 0;
        n0 = 2;
        n1 = 2;
        last = 1;
        exp_g.delete();
        while ((n0 + n1) > 0) begin
`ifdef AES_ARB_STRICT_PRIO_EN
            g = (n0 > 0) ? 0 : 1;
`else
            if ((n0 > 0) && (n1 > 0)) g = 1 - last;
            else g = (n0 > 0) ? 0 : 1;
`endif
            exp_g.push_back(g);
            last = g;
            if (g == 0) n0--; else n1--;
        end
        chk("grant_count", 32'(grants.size()), 4);
        for (int i = 0; i < grants.size() && i < exp_g.size(); i++)
            chk("grant_order", 32'(grants[i]), 32'(exp_g[i]));
        chk("sim_done", 32'(blocks_done), 4);

        // Input backpressure after the second word
        inw.delete();
        blk.delete();
        w0 = stall_wr;
        d0 = blocks_done;
        bp_arm = 1;
        add_block(0);
        foreach (src0[i]) blk.push_back(src0[i]);
        drive();
        drain(500);
        chk("bp_no_wr_stalled", 32'(stall_wr - w0), 0);
        chk("bp_writes", 32'(inw.size()), WPB);
        for (int i = 0; i < inw.size() && i < blk.size(); i++)
            chk("bp_word", inw[i], blk[i]);
        chk("bp_done", 32'(blocks_done - d0), 1);

        // Tag queue full while results are held back
        oe_mode = 1;
        w0 = wr_cnt;
        d0 = blocks_done;
        for (int b = 0; b <= TD; b++) add_block(0);
        drive();
        n = 0;
        while (((wr_cnt - w0) < TD * WPB) && (n < 400)) begin
            step();
            n++;
        end
        for (int i = 0; i < 20; i++) step();
        chk("full_writes", 32'(wr_cnt - w0), TD * WPB);
        chk("full_busy", 32'(busy), 1);
        chk("full_no_ready", 32'(req0_ready), 0);
        chk("full_pending_valid", 32'(req0_valid), 1);
        oe_mode = 0;
        drive();
        drain(3000);
        chk("full_release_writes", 32'(wr_cnt - w0), (TD + 1) * WPB);
        chk("full_done", 32'(blocks_done - d0), TD + 1);

        // Orphan result data
        do_reset();
        rd_cnt = 0;
        oe_mode = 2;
        drive();
        for (int i = 0; i < 3; i++) step();
        chk("orphan_flag", 32'(orphan_err), 1);
        chk("orphan_no_rd", 32'(rd_cnt), 0);
        oe_mode = 0;
        do_reset();
        chk("orphan_cleared", 32'(orphan_err), 0);

        // Reset in the middle of a block
        w0 = wr_cnt;
        add_block(0);
        drive();
        n = 0;
        while (((wr_cnt - w0) < 2) && (n < 50)) begin
            step();
            n++;
        end
        chk("midrst_two_words", 32'(wr_cnt - w0), 2);
        src0.delete();
        rst_main_sync = 1'b1;
        drive();
        step();
        rst_main_sync = 1'b0;
        exp0.delete();
        drive();
        check_reset_vals("midrst");
        add_block(0);
        drive();
        drain(500);
        chk("midrst_new_done", 32'(blocks_done), 1);
        chk("stall_wr_total", 32'(stall_wr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
